// File: rtl/qdma_tg_pkg.sv
// Shared types and constants for the QDMA traffic generator/checker blocks.
package qdma_tg_pkg;

  typedef enum logic [1:0] {IDLE, RECV, DONE} sink_state_e;

  localparam int unsigned CTRL_RUN_BIT   = 1;
  localparam int unsigned CTRL_CLR_BIT   = 2;
  localparam int unsigned DEF_DATA_WIDTH = 512;
  localparam int unsigned MTY_WIDTH      = 6;
  localparam logic [16:0] PKT_ACC_MAX    = 17'h1FFFF;

endpackage

// File: rtl/h2c_par_chk.sv
// Per-byte odd-parity check of one stream beat; bytes emptied by mty on the
// tlast beat are excluded from the check.
module h2c_par_chk
  import qdma_tg_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_WIDTH
) (
  input  logic [DATA_W-1:0]    tdata_i,
  input  logic [DATA_W/8-1:0]  dpar_i,
  input  logic [MTY_WIDTH-1:0] mty_i,
  input  logic                 tlast_i,
  output logic                 err_o
);

  localparam int unsigned BEN = DATA_W / 8;

  always_comb begin
    err_o = 1'b0;
    for (int unsigned i = 0; i < BEN; i++) begin
      if (!tlast_i || (i + 32'(mty_i) < BEN)) begin
        if (dpar_i[i] != ~^tdata_i[8*i +: 8]) begin
          err_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/h2c_flow_sink.sv
// H2C AXI-Stream sink: checks packet length and a 32-bit incrementing pattern,
// keeps run statistics. Define H2C_PARITY_CHK_EN to add the byte-parity check.
module h2c_flow_sink
  import qdma_tg_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned BYTE_WIDTH   = 48
) (
  input  logic                      axi_aclk,
  input  logic                      user_reset,
  input  logic [31:0]               control_reg,
  input  logic [15:0]               txr_size,
  input  logic [15:0]               num_pkt,
  input  logic [C_DATA_WIDTH-1:0]   h2c_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] h2c_dpar,
  input  logic [MTY_WIDTH-1:0]      h2c_mty,
  input  logic                      h2c_tvalid,
  input  logic                      h2c_tlast,
  output logic                      h2c_tready,
  output logic [CNT_WIDTH-1:0]      pkt_count,
  output logic [BYTE_WIDTH-1:0]     byte_count,
  output logic [CNT_WIDTH-1:0]      cycle_count,
  output logic [CNT_WIDTH-1:0]      len_err_count,
  output logic [CNT_WIDTH-1:0]      data_err_count,
  output logic                      h2c_end
);

  localparam int unsigned BEN = C_DATA_WIDTH / 8;

  sink_state_e           state_q, state_d;
  logic                  tready_q, end_q, in_pkt_q, in_pkt_d, started_q;
  logic [16:0]           run_pkts_q, acc_q;
  logic [31:0]           exp_pat_q;
  logic [CNT_WIDTH-1:0]  pkt_q, cyc_q, lerr_q, derr_q;
  logic [BYTE_WIDTH-1:0] bytes_q;

  logic        run, clr_stats, accept, last_pkt, new_run, cyc_active;
  logic [16:0] beat_bytes, acc_sum;
  logic [17:0] acc_wide;
  logic [BYTE_WIDTH:0] bytes_sum;
  logic        ev_vld, ev_last, ev_err;
  logic [16:0] ev_bytes;

  assign run      = control_reg[CTRL_RUN_BIT];
  assign accept   = h2c_tvalid && tready_q;
  assign last_pkt = (num_pkt != 16'd0) && ((run_pkts_q + 17'd1) == {1'b0, num_pkt});

  always_comb begin
    state_d  = state_q;
    in_pkt_d = in_pkt_q;
    case (state_q)
      IDLE: if (run) state_d = RECV;
      RECV: begin
        // Stopping waits for a packet boundary; an accepted non-last beat keeps us here.
        if (accept) begin
          in_pkt_d = !h2c_tlast;
          if (h2c_tlast && last_pkt)  state_d = DONE;
          else if (h2c_tlast && !run) state_d = IDLE;
        end else if (!in_pkt_q && !run) begin
          state_d = IDLE;
        end
      end
      DONE: if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign new_run    = (state_q == IDLE) && (state_d == RECV);
  assign clr_stats  = control_reg[CTRL_CLR_BIT] || new_run;
  assign cyc_active = (state_q == RECV) && (started_q || accept);
  assign beat_bytes = h2c_tlast ? (17'(BEN) - 17'(h2c_mty)) : 17'(BEN);

`ifdef H2C_PARITY_CHK_EN
  logic        par_err;
  logic        ev_vld_q, ev_last_q, ev_err_q;
  logic [16:0] ev_bytes_q;

  h2c_par_chk #(.DATA_W(C_DATA_WIDTH)) u_par_chk (
    .tdata_i (h2c_tdata),
    .dpar_i  (h2c_dpar),
    .mty_i   (h2c_mty),
    .tlast_i (h2c_tlast),
    .err_o   (par_err)
  );

  always_ff @(posedge axi_aclk) begin
    if (user_reset) begin
      ev_vld_q   <= 1'b0;
      ev_last_q  <= 1'b0;
      ev_err_q   <= 1'b0;
      ev_bytes_q <= '0;
    end else begin
      ev_vld_q   <= accept;
      ev_last_q  <= h2c_tlast;
      ev_err_q   <= (h2c_tdata[31:0] != exp_pat_q) || par_err;
      ev_bytes_q <= beat_bytes;
    end
  end

  assign ev_vld   = ev_vld_q;
  assign ev_last  = ev_last_q;
  assign ev_err   = ev_err_q;
  assign ev_bytes = ev_bytes_q;
`else
  assign ev_vld   = accept;
  assign ev_last  = h2c_tlast;
  assign ev_err   = (h2c_tdata[31:0] != exp_pat_q);
  assign ev_bytes = beat_bytes;
`endif

  assign acc_wide  = {1'b0, acc_q} + {1'b0, ev_bytes};
  assign acc_sum   = acc_wide[17] ? PKT_ACC_MAX : acc_wide[16:0];
  assign bytes_sum = {1'b0, bytes_q} + (BYTE_WIDTH+1)'(ev_bytes);

  always_ff @(posedge axi_aclk) begin
    if (user_reset) begin
      state_q    <= IDLE;
      tready_q   <= 1'b0;
      end_q      <= 1'b0;
      in_pkt_q   <= 1'b0;
      started_q  <= 1'b0;
      run_pkts_q <= '0;
      acc_q      <= '0;
      exp_pat_q  <= '0;
      pkt_q      <= '0;
      cyc_q      <= '0;
      lerr_q     <= '0;
      derr_q     <= '0;
      bytes_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_pkt_q <= in_pkt_d;
      tready_q <= (state_d == RECV);
      end_q    <= (state_q == RECV) && (state_d == DONE);

      if (new_run)     started_q <= 1'b0;
      else if (accept) started_q <= 1'b1;

      if (new_run)     acc_q <= '0;
      else if (ev_vld) acc_q <= ev_last ? 17'd0 : acc_sum;

      if (clr_stats) begin
        exp_pat_q  <= '0;
        run_pkts_q <= '0;
        pkt_q      <= '0;
        cyc_q      <= '0;
        lerr_q     <= '0;
        derr_q     <= '0;
        bytes_q    <= '0;
      end else begin
        if (accept) exp_pat_q <= exp_pat_q + 32'd1;
        if (accept && h2c_tlast && (run_pkts_q != '1)) run_pkts_q <= run_pkts_q + 17'd1;
        if (cyc_active && (cyc_q != '1)) cyc_q <= cyc_q + CNT_WIDTH'(1);
        if (ev_vld) begin
          bytes_q <= bytes_sum[BYTE_WIDTH] ? '1 : bytes_sum[BYTE_WIDTH-1:0];
          if (ev_err && (derr_q != '1)) derr_q <= derr_q + CNT_WIDTH'(1);
          if (ev_last) begin
            if (pkt_q != '1) pkt_q <= pkt_q + CNT_WIDTH'(1);
            if ((acc_sum != {1'b0, txr_size}) && (lerr_q != '1)) lerr_q <= lerr_q + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{control_reg[31:3], control_reg[0], h2c_tdata[C_DATA_WIDTH-1:32], h2c_dpar};

  assign h2c_tready     = tready_q;
  assign h2c_end        = end_q;
  assign pkt_count      = pkt_q;
  assign byte_count     = bytes_q;
  assign cycle_count    = cyc_q;
  assign len_err_count  = lerr_q;
  assign data_err_count = derr_q;

endmodule

// File: tb/tb_h2c_flow_sink.sv
// Self-checking bench for h2c_flow_sink: randomized beats against a packet-level reference model.
module tb_h2c_flow_sink;

  localparam int DW  = 512;
  localparam int BEN = DW / 8;

  logic          clk = 1'b0;
  logic          user_reset;
  logic [31:0]   control_reg;
  logic [15:0]   txr_size, num_pkt;
  logic [DW-1:0] h2c_tdata;
  logic [BEN-1:0] h2c_dpar;
  logic [5:0]    h2c_mty;
  logic          h2c_tvalid, h2c_tlast, h2c_tready, h2c_end;
  logic [31:0]   pkt_count, cycle_count, len_err_count, data_err_count;
  logic [47:0]   byte_count;

  always #5 clk = ~clk;

  h2c_flow_sink #(.C_DATA_WIDTH(DW), .CNT_WIDTH(32), .BYTE_WIDTH(48)) dut (
    .axi_aclk(clk), .user_reset(user_reset), .control_reg(control_reg),
    .txr_size(txr_size), .num_pkt(num_pkt), .h2c_tdata(h2c_tdata), .h2c_dpar(h2c_dpar),
    .h2c_mty(h2c_mty), .h2c_tvalid(h2c_tvalid), .h2c_tlast(h2c_tlast), .h2c_tready(h2c_tready),
    .pkt_count(pkt_count), .byte_count(byte_count), .cycle_count(cycle_count),
    .len_err_count(len_err_count), .data_err_count(data_err_count), .h2c_end(h2c_end)
  );

  int total = 0, passed = 0, end_cnt = 0;
  logic [31:0] m_pkt, m_lerr, m_derr, m_pat;
  logic [47:0] m_bytes;
  int unsigned m_acc;
  bit  got_first, flip_par;
  time t_first, t_last;

  always @(negedge clk) if (h2c_end === 1'b1) end_cnt++;

  task automatic model_reset();
    m_pkt = 0; m_lerr = 0; m_derr = 0; m_pat = 0; m_bytes = 0; m_acc = 0; got_first = 0;
  endtask

  task automatic send_beat(input logic [31:0] word, input bit last, input logic [5:0] mty, output int waited);
    int unsigned nb;
    @(negedge clk);
    for (int i = 0; i < DW / 32; i++) h2c_tdata[32*i +: 32] = $urandom;
    h2c_tdata[31:0] = word;
    h2c_mty = last ? mty : 6'($urandom);
`ifdef H2C_PARITY_CHK_EN
    for (int i = 0; i < BEN; i++) h2c_dpar[i] = ~^h2c_tdata[8*i +: 8];
    if (flip_par) h2c_dpar[0] = ~h2c_dpar[0];
`else
    for (int i = 0; i < BEN / 32; i++) h2c_dpar[32*i +: 32] = $urandom;
`endif
    h2c_tvalid = 1'b1; h2c_tlast = last;
    waited = 0;
    while (h2c_tready !== 1'b1 && waited < 200) begin @(negedge clk); waited++; end
    if (h2c_tready !== 1'b1) begin
      total++;
      $display("FAIL beat_accept_timeout: tready=%b after %0d cycles, need 1", h2c_tready, waited);
    end else begin
      nb = last ? (BEN - 32'(mty)) : BEN;
      m_bytes += 48'(nb);
      m_acc = (m_acc + nb > 131071) ? 131071 : m_acc + nb;
      if (word != m_pat || flip_par) m_derr++;
      m_pat++;
      if (last) begin
        m_pkt++;
        if (m_acc != 32'(txr_size)) m_lerr++;
        m_acc = 0;
      end
    end
    @(posedge clk);
    if (!got_first) begin t_first = $time; got_first = 1; end
    t_last = $time;
    #1 h2c_tvalid = 1'b0; h2c_tlast = 1'b0;
  endtask

  task automatic send_pkt(input int nbeats, input logic [5:0] mty_last, input int bad_beat,
                          input int max_gap, input int stop_beat, output int waits);
    logic [31:0] w;
    int wt;
    waits = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
      w = m_pat;
      if (b == bad_beat) w = w ^ (32'd1 << $urandom_range(0, 31));
      if (b == stop_beat) control_reg[1] = 1'b0;
      send_beat(w, b == nbeats - 1, mty_last, wt);
      waits += wt;
    end
  endtask

  task automatic start_run();
    int n = 0;
    @(negedge clk);
    control_reg = 32'h2;
    model_reset();
    while (h2c_tready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (h2c_tready !== 1'b1) begin total++; $display("FAIL start_run: tready=%b, need 1", h2c_tready); end
  endtask

  task automatic stop_run();
    int n = 0;
    @(negedge clk);
    control_reg = 32'h0;
    while (h2c_tready !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (h2c_tready !== 1'b0) begin total++; $display("FAIL stop_run: tready=%b, need 0", h2c_tready); end
  endtask

  task automatic test_reset();
    user_reset = 1; control_reg = 0; txr_size = 16'd4096; num_pkt = 0;
    h2c_tvalid = 0; h2c_tlast = 0; h2c_tdata = '0; h2c_dpar = '0; h2c_mty = '0; flip_par = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (h2c_tready !== 1'b0) $display("FAIL rst_tready: got %b want 0", h2c_tready); else passed++;
    total++; if (h2c_end !== 1'b0) $display("FAIL rst_end: got %b want 0", h2c_end); else passed++;
    total++; if ({pkt_count, cycle_count, len_err_count, data_err_count, byte_count} !== '0)
      $display("FAIL rst_counters: got pkt=%0d byte=%0d cyc=%0d lerr=%0d derr=%0d want all 0",
               pkt_count, byte_count, cycle_count, len_err_count, data_err_count);
    else passed++;
    user_reset = 0;
  endtask

  task automatic test_full_run();
    int w;
    txr_size = 16'd4096; num_pkt = 16'd32; end_cnt = 0;
    start_run();
    for (int p = 0; p < 32; p++) send_pkt(64, 6'd0, -1, 0, -1, w);
    repeat (3) @(negedge clk);
    total++; if (pkt_count !== m_pkt) $display("FAIL full_pkt: got %0d want %0d", pkt_count, m_pkt); else passed++;
    total++; if (byte_count !== m_bytes) $display("FAIL full_bytes: got %0d want %0d", byte_count, m_bytes); else passed++;
    total++; if (len_err_count !== m_lerr) $display("FAIL full_lerr: got %0d want %0d", len_err_count, m_lerr); else passed++;
    total++; if (data_err_count !== m_derr) $display("FAIL full_derr: got %0d want %0d", data_err_count, m_derr); else passed++;
    total++; if (end_cnt !== 1) $display("FAIL full_end_pulses: got %0d want 1", end_cnt); else passed++;
    total++; if (h2c_tready !== 1'b0) $display("FAIL full_done_tready: got %b want 0", h2c_tready); else passed++;
    total++; if (cycle_count !== 32'((t_last - t_first) / 10 + 1))
      $display("FAIL full_cycles: got %0d want %0d", cycle_count, (t_last - t_first) / 10 + 1);
    else passed++;
    stop_run();
  endtask

  task automatic test_short_pkts();
    int w, n;
    txr_size = 16'd100; num_pkt = 16'd0;
    start_run();
    n = $urandom_range(3, 8);
    for (int p = 0; p < n; p++) send_pkt(2, 6'd28, -1, 3, -1, w);
    repeat (3) @(negedge clk);
    total++; if (len_err_count !== m_lerr) $display("FAIL short_lerr: got %0d want %0d", len_err_count, m_lerr); else passed++;
    total++; if (byte_count !== m_bytes) $display("FAIL short_bytes: got %0d want %0d", byte_count, m_bytes); else passed++;
    total++; if (pkt_count !== m_pkt) $display("FAIL short_pkt: got %0d want %0d", pkt_count, m_pkt); else passed++;
    total++; if (h2c_tready !== 1'b1) $display("FAIL short_still_recv: got %b want 1", h2c_tready); else passed++;
    stop_run();
  endtask

  task automatic test_len_err();
    int w;
    txr_size = 16'd4096; num_pkt = 16'd0;
    start_run();
    send_pkt(63, 6'd0, -1, 1, -1, w);
    repeat (3) @(negedge clk);
    total++; if (len_err_count !== m_lerr) $display("FAIL lenerr_lerr: got %0d want %0d", len_err_count, m_lerr); else passed++;
    total++; if (pkt_count !== m_pkt) $display("FAIL lenerr_pkt: got %0d want %0d", pkt_count, m_pkt); else passed++;
    stop_run();
  endtask

  task automatic test_data_err();
    int w;
    txr_size = 16'd4096; num_pkt = 16'd0;
    start_run();
    send_pkt(64, 6'd0, 10, 2, -1, w);
    send_pkt(64, 6'd0, -1, 0, -1, w);
    repeat (3) @(negedge clk);
    total++; if (data_err_count !== m_derr) $display("FAIL dataerr_derr: got %0d want %0d", data_err_count, m_derr); else passed++;
    total++; if (len_err_count !== m_lerr) $display("FAIL dataerr_lerr: got %0d want %0d", len_err_count, m_lerr); else passed++;
    total++; if (pkt_count !== m_pkt) $display("FAIL dataerr_pkt: got %0d want %0d", pkt_count, m_pkt); else passed++;
    stop_run();
  endtask

  task automatic test_stop_midpkt();
    int waits;
    txr_size = 16'd4096; num_pkt = 16'd0;
    start_run();
    send_pkt(64, 6'd0, -1, 0, 5, waits);
    repeat (2) @(negedge clk);
    total++; if (waits !== 0) $display("FAIL stop_tready_held: got %0d stalled cycles want 0", waits); else passed++;
    total++; if (h2c_tready !== 1'b0) $display("FAIL stop_idle_tready: got %b want 0", h2c_tready); else passed++;
    total++; if (pkt_count !== m_pkt) $display("FAIL stop_pkt: got %0d want %0d", pkt_count, m_pkt); else passed++;
    total++; if (byte_count !== m_bytes) $display("FAIL stop_bytes: got %0d want %0d", byte_count, m_bytes); else passed++;
    stop_run();
  endtask

  task automatic test_clear();
    int w;
    txr_size = 16'd4096; num_pkt = 16'd0;
    start_run();
    send_pkt(64, 6'd0, 3, 1, -1, w);
    @(negedge clk); control_reg = 32'h6;
    @(negedge clk);
    m_pkt = 0; m_lerr = 0; m_derr = 0; m_pat = 0; m_bytes = 0;
    total++; if ({pkt_count, byte_count, data_err_count} !== '0)
      $display("FAIL clear_zero: got pkt=%0d byte=%0d derr=%0d want 0", pkt_count, byte_count, data_err_count);
    else passed++;
    control_reg = 32'h2;
    send_pkt(64, 6'd0, -1, 1, -1, w);
    repeat (3) @(negedge clk);
    total++; if (data_err_count !== m_derr) $display("FAIL clear_pat_restart: got %0d want %0d", data_err_count, m_derr); else passed++;
    total++; if (pkt_count !== m_pkt) $display("FAIL clear_pkt: got %0d want %0d", pkt_count, m_pkt); else passed++;
    stop_run();
  endtask

  task automatic test_reset_midpkt();
    int w;
    txr_size = 16'd4096; num_pkt = 16'd0;
    start_run();
    for (int b = 0; b < 20; b++) send_beat(m_pat, 1'b0, 6'd0, w);
    @(negedge clk); user_reset = 1;
    @(negedge clk);
    total++; if (h2c_tready !== 1'b0) $display("FAIL rstmid_tready: got %b want 0", h2c_tready); else passed++;
    total++; if ({pkt_count, byte_count, cycle_count, data_err_count} !== '0)
      $display("FAIL rstmid_counters: got pkt=%0d byte=%0d cyc=%0d derr=%0d want 0",
               pkt_count, byte_count, cycle_count, data_err_count);
    else passed++;
    user_reset = 0;
    model_reset();
    @(negedge clk);
    total++; if (h2c_tready !== 1'b1) $display("FAIL rstmid_restart_tready: got %b want 1", h2c_tready); else passed++;
    send_pkt(64, 6'd0, -1, 1, -1, w);
`ifdef H2C_PARITY_CHK_EN
    flip_par = 1;
    send_pkt(1, 6'd0, -1, 0, -1, w);
    flip_par = 0;
    m_lerr = m_lerr;
`endif
    repeat (4) @(negedge clk);
    total++; if (pkt_count !== m_pkt) $display("FAIL rstmid_pkt: got %0d want %0d", pkt_count, m_pkt); else passed++;
    total++; if (len_err_count !== m_lerr) $display("FAIL rstmid_lerr: got %0d want %0d", len_err_count, m_lerr); else passed++;
    total++; if (data_err_count !== m_derr) $display("FAIL rstmid_derr: got %0d want %0d", data_err_count, m_derr); else passed++;
    stop_run();
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_short_pkts();
    test_len_err();
    test_data_err();
    test_stop_midpkt();
    test_clear();
    test_reset_midpkt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", passed, total);
    $fatal(1);
  end

endmodule
